// File: rtl/cache_pkg.sv
// Shared constants and the fill state encoding for the 4-way cache line-fill path.
package cache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int WAY_W      = 2;
  localparam int BEAT_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    TAG,
    ABORT
  } fill_state_e;

endpackage

// File: rtl/line_offset_counter.sv
// 4-bit loadable wrap counter that walks the byte offset of a line fill.
// Loading takes priority over incrementing; 15 naturally wraps to 0.
module line_offset_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                inc,
  input  logic [OFFSET_W-1:0] load_val,
  output logic [OFFSET_W-1:0] offset
);

  // Offset register: load the critical byte, then step one byte per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else if (load) begin
      offset <= load_val;
    end else if (inc) begin
      offset <= offset + 1'b1;
    end
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache line-fill controller: requests a 16-byte line, writes the returned bytes
// critical-byte-first into the data array, then validates the tag or aborts on error.
module line_fill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WAY_W  = cache_pkg::WAY_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_req,
  input  logic [ADDR_W-1:0]              miss_addr,
  input  logic [WAY_W-1:0]               miss_way,
  output logic                           fill_busy,
  output logic                           fill_done,
  output logic                           fill_err,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_ack,
  input  logic                           mem_rvalid,
  input  logic [7:0]                     mem_rdata,
  input  logic                           mem_rerr,
  output logic                           arr_we,
  output logic [WAY_W-1:0]               arr_way,
  output logic [ADDR_W-cache_pkg::OFFSET_W-1:0] arr_line,
  output logic [3:0]                     arr_byte_sel,
  output logic [7:0]                     arr_wdata,
  output logic                           crit_valid,
  output logic [7:0]                     crit_data,
  output logic                           tag_we
);

  import cache_pkg::*;

  fill_state_e         state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [OFFSET_W-1:0] offset;
  logic                ctr_load;
  logic                good_beat;

  // A new fill is only accepted once the busy flag of the previous one has dropped.
  assign ctr_load  = (state == IDLE) && !fill_busy && miss_req;
  assign good_beat = (state == FILL) && mem_rvalid && !mem_rerr;

  line_offset_counter u_offset (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .inc      (good_beat),
    .load_val (miss_addr[OFFSET_W-1:0]),
    .offset   (offset)
  );

  // Fill sequencer with registered outputs; pulse outputs default low every cycle.
  // After TAG the busy flag is held for one extra IDLE cycle so tag_we/fill_done
  // land while the fill still reads as busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
      fill_err     <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      arr_we       <= 1'b0;
      arr_way      <= '0;
      arr_line     <= '0;
      arr_byte_sel <= '0;
      arr_wdata    <= '0;
      crit_valid   <= 1'b0;
      crit_data    <= '0;
      tag_we       <= 1'b0;
    end else begin
      arr_we     <= 1'b0;
      crit_valid <= 1'b0;
      tag_we     <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_busy) begin
            fill_busy <= 1'b0;
          end else if (miss_req) begin
            mem_addr  <= {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            arr_line  <= miss_addr[ADDR_W-1:OFFSET_W];
            arr_way   <= miss_way;
            beat_cnt  <= '0;
            mem_req   <= 1'b1;
            fill_busy <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            if (mem_rerr) begin
              fill_err <= 1'b1;
              state    <= ABORT;
            end else begin
              arr_we       <= 1'b1;
              arr_byte_sel <= offset;
              arr_wdata    <= mem_rdata;
              if (beat_cnt == '0) begin
                crit_valid <= 1'b1;
                crit_data  <= mem_rdata;
              end
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == BEAT_W'(LINE_BYTES - 1)) begin
                state <= TAG;
              end
            end
          end
        end
        TAG: begin
          tag_we    <= 1'b1;
          fill_done <= 1'b1;
          state     <= IDLE;
        end
        ABORT: begin
          fill_busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Scoreboard bench for line_fill_ctrl: expected array writes (with their cycle)
// are queued as beats are driven and popped when arr_we appears.
module tb_line_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic [1:0]  miss_way = '0;
  logic        fill_busy, fill_done, fill_err, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_rerr = 1'b0;
  logic        arr_we;
  logic [1:0]  arr_way;
  logic [27:0] arr_line;
  logic [3:0]  arr_byte_sel;
  logic [7:0]  arr_wdata;
  logic        crit_valid;
  logic [7:0]  crit_data;
  logic        tag_we;

  line_fill_ctrl #(.ADDR_W(32), .WAY_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .miss_way     (miss_way),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .fill_err     (fill_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_rerr     (mem_rerr),
    .arr_we       (arr_we),
    .arr_way      (arr_way),
    .arr_line     (arr_line),
    .arr_byte_sel (arr_byte_sel),
    .arr_wdata    (arr_wdata),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .tag_we       (tag_we)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  sel;
    logic [7:0]  data;
    logic [1:0]  way;
    logic [27:0] line;
  } wr_t;

  wr_t exp_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [3:0]  m_sel;
  logic [1:0]  m_way;
  logic [27:0] m_line;

  int          tag_cnt = 0, done_cnt = 0, err_cnt = 0, crit_cnt = 0;
  int          tag_cyc = 0, crit_cyc = 0;
  logic [7:0]  crit_d = '0;
  logic [1:0]  tag_way = '0;
  logic [27:0] tag_line = '0;

  logic [88:0] all_out;
  assign all_out = {fill_busy, fill_done, fill_err, mem_req, mem_addr, arr_we, arr_way,
                    arr_line, arr_byte_sel, arr_wdata, crit_valid, crit_data, tag_we};

  always #5 clk = ~clk;

  // Cycle stamp: value N between two rising edges means "cycle N".
  always @(posedge clk) cyc++;

  wr_t w;
  // Monitor: pop the scoreboard on every array write and record pulse events.
  always @(negedge clk) begin
    if (!rst) begin
      if (arr_we) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("[TB] FAIL unexpected_write cyc=%0d sel=%h data=%h", cyc, arr_byte_sel, arr_wdata);
        end else begin
          w = exp_q.pop_front();
          if ({cyc, arr_byte_sel, arr_wdata, arr_way, arr_line} !== {w.cyc, w.sel, w.data, w.way, w.line}) begin
            errs++;
            $display("[TB] FAIL array_write got cyc=%0d sel=%h data=%h way=%0d line=%h expected cyc=%0d sel=%h data=%h way=%0d line=%h",
                     cyc, arr_byte_sel, arr_wdata, arr_way, arr_line, w.cyc, w.sel, w.data, w.way, w.line);
          end
        end
      end
      if (tag_we) begin
        tag_cnt++;
        tag_cyc  = cyc;
        tag_way  = arr_way;
        tag_line = arr_line;
      end
      if (fill_done) done_cnt++;
      if (fill_err) err_cnt++;
      if (crit_valid) begin
        crit_cnt++;
        crit_cyc = cyc;
        crit_d   = crit_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [31:0] a, input logic [1:0] wy);
    miss_req  = 1'b1;
    miss_addr = a;
    miss_way  = wy;
    m_sel     = a[3:0];
    m_way     = wy;
    m_line    = a[31:4];
    step();
    miss_req  = 1'b0;
  endtask

  task automatic ack_now();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic e);
    wr_t ent;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    mem_rerr   = e;
    if (!e) begin
      ent.cyc  = cyc + 1;
      ent.sel  = m_sel;
      ent.data = d;
      ent.way  = m_way;
      ent.line = m_line;
      exp_q.push_back(ent);
      m_sel = m_sel + 4'd1;
    end
    step();
    mem_rvalid = 1'b0;
    mem_rerr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("[TB] FAIL reset_outputs got %h expected 0", all_out);
    end
    rst = 1'b0;
    step();
    vecs++;
    if ({fill_busy, mem_req, arr_we} !== 3'b000) begin
      errs++;
      $display("[TB] FAIL idle_after_reset got %b expected 000", {fill_busy, mem_req, arr_we});
    end
  endtask

  task automatic test_basic_fill();
    int c0, t, crit0, done0;
    c0 = cyc;
    crit0 = crit_cnt;
    done0 = done_cnt;
    issue_miss(32'h0000_1230, 2'd2);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({mem_req, fill_busy, mem_addr} !== {2'b11, 32'h0000_1230}) begin
        errs++;
        $display("[TB] FAIL basic_req c%0d got req=%b busy=%b addr=%h expected 1 1 00001230", i + 1, mem_req, fill_busy, mem_addr);
      end
      if (i < 2) step();
    end
    ack_now();
    vecs++;
    if ({mem_req, fill_busy} !== 2'b01) begin
      errs++;
      $display("[TB] FAIL basic_req_drop got req/busy=%b expected 01", {mem_req, fill_busy});
    end
    for (int i = 0; i < 16; i++) send_beat(8'hA0 + 8'(i), 1'b0);
    t = cyc - 1;
    step();
    vecs++;
    if ({tag_we, fill_done, fill_busy} !== 3'b111) begin
      errs++;
      $display("[TB] FAIL basic_tag_pulse got %b expected 111", {tag_we, fill_done, fill_busy});
    end
    step();
    vecs++;
    if ({tag_we, fill_done, fill_busy} !== 3'b000) begin
      errs++;
      $display("[TB] FAIL basic_busy_drop got %b expected 000", {tag_we, fill_done, fill_busy});
    end
    vecs++;
    if ({crit_cnt, crit_cyc, crit_d} !== {crit0 + 1, c0 + 5, 8'hA0}) begin
      errs++;
      $display("[TB] FAIL basic_crit got cnt=%0d cyc=%0d data=%h expected cnt=%0d cyc=%0d data=a0",
               crit_cnt, crit_cyc, crit_d, crit0 + 1, c0 + 5);
    end
    vecs++;
    if ({tag_cyc, tag_way, tag_line, done_cnt} !== {t + 2, 2'd2, 28'h0000123, done0 + 1}) begin
      errs++;
      $display("[TB] FAIL basic_tag got cyc=%0d way=%0d line=%h done=%0d expected cyc=%0d way=2 line=0000123 done=%0d",
               tag_cyc, tag_way, tag_line, done_cnt, t + 2, done0 + 1);
    end
    vecs++;
    if (exp_q.size() !== 0) begin
      errs++;
      $display("[TB] FAIL basic_missing_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_gapped_fill();
    logic [7:0] d, first;
    int done0;
    done0 = done_cnt;
    first = '0;
    issue_miss(32'h0000_123D, 2'd1);
    ack_now();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      if (i == 0) first = d;
      send_beat(d, 1'b0);
      if (i % 3 == 1) step();
      if (i % 5 == 2) begin
        step();
        step();
      end
    end
    repeat (3) step();
    vecs++;
    if ({crit_d, exp_q.size() == 0, done_cnt == done0 + 1, fill_busy} !== {first, 3'b110}) begin
      errs++;
      $display("[TB] FAIL gapped_fill got crit=%h drained=%b done_inc=%b busy=%b expected crit=%h 1 1 0",
               crit_d, exp_q.size() == 0, done_cnt == done0 + 1, fill_busy, first);
    end
    vecs++;
    if ({tag_way, tag_line} !== {2'd1, 28'h0000123}) begin
      errs++;
      $display("[TB] FAIL gapped_tag got way=%0d line=%h expected way=1 line=0000123", tag_way, tag_line);
    end
  endtask

  task automatic test_error_abort();
    int tag0, done0, err0;
    tag0 = tag_cnt;
    done0 = done_cnt;
    err0 = err_cnt;
    issue_miss(32'h0000_4567, 2'd3);
    ack_now();
    for (int i = 0; i < 4; i++) send_beat(8'h50 + 8'(i), 1'b0);
    send_beat(8'hEE, 1'b1);
    vecs++;
    if ({fill_err, fill_busy, arr_we} !== 3'b110) begin
      errs++;
      $display("[TB] FAIL err_pulse got err/busy/we=%b expected 110", {fill_err, fill_busy, arr_we});
    end
    step();
    vecs++;
    if ({fill_err, fill_busy} !== 2'b00) begin
      errs++;
      $display("[TB] FAIL err_busy_drop got err/busy=%b expected 00", {fill_err, fill_busy});
    end
    step();
    step();
    vecs++;
    if ({tag_cnt == tag0, done_cnt == done0, err_cnt == err0 + 1, exp_q.size() == 0} !== 4'b1111) begin
      errs++;
      $display("[TB] FAIL err_events got tag=%0d done=%0d err=%0d pending=%0d expected tag=%0d done=%0d err=%0d pending=0",
               tag_cnt, done_cnt, err_cnt, exp_q.size(), tag0, done0, err0 + 1);
    end
  endtask

  task automatic test_ignored_inputs();
    int done0;
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'($urandom);
      step();
      vecs++;
      if ({fill_busy, mem_req} !== 2'b00) begin
        errs++;
        $display("[TB] FAIL idle_noise got busy/req=%b expected 00", {fill_busy, mem_req});
      end
    end
    mem_rvalid = 1'b0;
    issue_miss(32'h0000_9AB0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      miss_req   = 1'b1;
      miss_addr  = 32'hFFFF_FFF5;
      miss_way   = 2'd3;
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h77;
      step();
      vecs++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_9AB0}) begin
        errs++;
        $display("[TB] FAIL req_noise got req=%b addr=%h expected 1 00009ab0", mem_req, mem_addr);
      end
    end
    miss_req   = 1'b0;
    mem_rvalid = 1'b0;
    ack_now();
    for (int i = 0; i < 16; i++) begin
      miss_req = (i % 2 == 0);
      send_beat(8'h10 + 8'(i), 1'b0);
    end
    miss_req = 1'b0;
    repeat (3) step();
    vecs++;
    if ({fill_busy, mem_req, done_cnt == done0 + 1, tag_way, tag_line} !== {3'b001, 2'd0, 28'h00009AB}) begin
      errs++;
      $display("[TB] FAIL busy_miss_ignored got busy=%b req=%b done_inc=%b way=%0d line=%h expected 0 0 1 way=0 line=00009ab",
               fill_busy, mem_req, done_cnt == done0 + 1, tag_way, tag_line);
    end
  endtask

  task automatic test_reset_mid_fill();
    int tag0, done0;
    tag0 = tag_cnt;
    issue_miss(32'h0000_8880, 2'd0);
    ack_now();
    for (int i = 0; i < 7; i++) send_beat(8'hC0 + 8'(i), 1'b0);
    step();
    rst = 1'b1;
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("[TB] FAIL midfill_reset_outputs got %h expected 0", all_out);
    end
    step();
    step();
    rst = 1'b0;
    step();
    vecs++;
    if ({tag_cnt == tag0, exp_q.size() == 0, fill_busy} !== 3'b110) begin
      errs++;
      $display("[TB] FAIL midfill_no_tag got tag=%0d pending=%0d busy=%b expected tag=%0d pending=0 busy=0",
               tag_cnt, exp_q.size(), fill_busy, tag0);
    end
    done0 = done_cnt;
    issue_miss(32'h0000_8885, 2'd0);
    ack_now();
    for (int i = 0; i < 16; i++) send_beat(8'hD0 + 8'(i), 1'b0);
    repeat (3) step();
    vecs++;
    if ({done_cnt == done0 + 1, crit_d, tag_line, exp_q.size() == 0} !== {1'b1, 8'hD0, 28'h0000888, 1'b1}) begin
      errs++;
      $display("[TB] FAIL refill_after_reset got done_inc=%b crit=%h line=%h drained=%b expected 1 d0 0000888 1",
               done_cnt == done0 + 1, crit_d, tag_line, exp_q.size() == 0);
    end
  endtask

  task automatic test_back_to_back();
    int t, done0;
    done0 = done_cnt;
    issue_miss(32'h0000_2000, 2'd1);
    miss_req  = 1'b1;
    miss_addr = 32'h0000_3008;
    miss_way  = 2'd0;
    ack_now();
    for (int i = 0; i < 16; i++) send_beat(8'h20 + 8'(i), 1'b0);
    t = cyc - 1;
    m_sel  = 4'h8;
    m_way  = 2'd0;
    m_line = 28'h0000300;
    step();
    vecs++;
    if ({fill_busy, fill_done, mem_req} !== 3'b110) begin
      errs++;
      $display("[TB] FAIL b2b_first_done got busy/done/req=%b expected 110 at cyc %0d", {fill_busy, fill_done, mem_req}, t + 2);
    end
    step();
    vecs++;
    if ({fill_busy, mem_req} !== 2'b00) begin
      errs++;
      $display("[TB] FAIL b2b_gap got busy/req=%b expected 00", {fill_busy, mem_req});
    end
    step();
    miss_req = 1'b0;
    vecs++;
    if ({fill_busy, mem_req, mem_addr} !== {2'b11, 32'h0000_3000}) begin
      errs++;
      $display("[TB] FAIL b2b_second_req got busy=%b req=%b addr=%h expected 1 1 00003000", fill_busy, mem_req, mem_addr);
    end
    ack_now();
    for (int i = 0; i < 16; i++) send_beat(8'h30 + 8'(i), 1'b0);
    repeat (3) step();
    vecs++;
    if ({done_cnt == done0 + 2, tag_way, tag_line, exp_q.size() == 0} !== {1'b1, 2'd0, 28'h0000300, 1'b1}) begin
      errs++;
      $display("[TB] FAIL b2b_second_fill got done_inc2=%b way=%0d line=%h drained=%b expected 1 0 0000300 1",
               done_cnt == done0 + 2, tag_way, tag_line, exp_q.size() == 0);
    end
  endtask

  // Main sequence.
  initial begin
    test_reset();
    test_basic_fill();
    test_gapped_fill();
    test_error_abort();
    test_ignored_inputs();
    test_reset_mid_fill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
